// File: rtl/riscv_pkg.sv
// Shared widths and the {pc, instr} record passed from fetch to decode.
package riscv_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO used for the decode queue and the in-flight address FIFO.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = $bits(fetch_entry_t)
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_empty = (count == '0);
    assign o_full  = (count == CNT_W'(DEPTH));
    assign o_count = count;
    assign do_pop  = i_pop & !o_empty;
    assign do_push = i_push & (!o_full | do_pop);

    // Empty reads as zero so the head never leaks stale payload.
    assign o_head_data = o_empty ? '0 : mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn || i_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues PC-addressed word fetches and queues {pc, instr} for decode.
// Handshakes: a transfer happens on any cycle where valid (o_imem_req / o_id_valid) and
// ready (i_imem_gnt / i_id_ready) are both high; a valid source holds its payload until then.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int QUEUE_DEPTH     = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_pc_stall,
    input  logic            i_flush,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [ILEN-1:0] i_imem_rdata,
    output logic            o_id_valid,
    output logic [XLEN-1:0] o_id_pc,
    output logic [ILEN-1:0] o_id_instr,
    input  logic            i_id_ready
);

    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int QCNT_W = $clog2(QUEUE_DEPTH + 1);

    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  kill_cnt;
    logic [QCNT_W-1:0] q_count;
    logic              q_full;
    logic              q_empty;
    fetch_entry_t      q_head;
    fetch_entry_t      q_push_data;
    logic [XLEN-1:0]   af_head;
    logic [CNT_W-1:0]  af_count;
    logic              af_full;
    logic              af_empty;
    logic [31:0]       live_cnt;
    logic              fire;
    logic              rsp_keep;
    logic              rsp_kill;
    logic              id_pop;

    // Every request that will still land in the queue needs a free slot reserved for it.
    assign live_cnt   = 32'(q_count) + 32'(outstanding) - 32'(kill_cnt);
    assign o_imem_req = i_rstn & !i_flush
                      & (outstanding < CNT_W'(MAX_OUTSTANDING))
                      & (live_cnt < 32'(QUEUE_DEPTH));
    assign o_imem_addr = i_pc;
    assign fire        = o_imem_req & i_imem_gnt;
    assign o_pc_stall  = !fire;

    assign rsp_kill = i_imem_rvalid & (kill_cnt != '0);
    assign rsp_keep = i_imem_rvalid & (kill_cnt == '0);
    assign id_pop   = o_id_valid & i_id_ready & !i_flush;

    assign q_push_data = '{pc: af_head, instr: i_imem_rdata};

    assign o_id_valid = i_rstn & !q_empty;
    assign o_id_pc    = i_rstn ? q_head.pc : '0;
    assign o_id_instr = i_rstn ? q_head.instr : '0;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            outstanding <= '0;
            kill_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(fire) - CNT_W'(i_imem_rvalid);
            // A redirect condemns whatever is still unanswered after this cycle's response.
            if (i_flush) begin
                kill_cnt <= outstanding - CNT_W'(i_imem_rvalid);
            end else if (rsp_kill) begin
                kill_cnt <= kill_cnt - CNT_W'(1);
            end
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_decode_q (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_flush     (i_flush),
        .i_push      (rsp_keep),
        .i_push_data (q_push_data),
        .i_pop       (id_pop),
        .o_head_data (q_head),
        .o_count     (q_count),
        .o_full      (q_full),
        .o_empty     (q_empty)
    );

    // In-flight addresses are never flushed: killed responses still pop their entry.
    fetch_queue #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (XLEN)
    ) u_addr_fifo (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_flush     (1'b0),
        .i_push      (fire),
        .i_push_data (i_pc),
        .i_pop       (i_imem_rvalid),
        .o_head_data (af_head),
        .o_count     (af_count),
        .o_full      (af_full),
        .o_empty     (af_empty)
    );

    always @(posedge i_clk) begin
        if (i_rstn) begin
            assert (!(i_imem_rvalid && outstanding == '0));
            assert (!(i_imem_rvalid && af_empty));
            assert (!(rsp_keep && q_full));
            assert (!(fire && af_full && !i_imem_rvalid));
            assert (af_count == outstanding);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: PC block and imem responder models, scoreboard on decode pops.
module tb_fetch_unit;

    logic        i_clk;
    logic        i_rstn;
    logic [63:0] i_pc;
    logic        o_pc_stall;
    logic        i_flush;
    logic        o_imem_req;
    logic [63:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_id_valid;
    logic [63:0] o_id_pc;
    logic [31:0] o_id_instr;
    logic        i_id_ready;

    int          checks = 0;
    int          errors = 0;
    logic [95:0] exp_q[$];
    logic [63:0] pend_q[$];
    logic        gnt_en;
    logic        resp_en;
    logic [63:0] pc_limit;
    logic [63:0] flush_pc;

    fetch_unit dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_pc          (i_pc),
        .o_pc_stall    (o_pc_stall),
        .i_flush       (i_flush),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_id_valid    (o_id_valid),
        .o_id_pc       (o_id_pc),
        .o_id_instr    (o_id_instr),
        .i_id_ready    (i_id_ready)
    );

    // Clock / watchdog
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    // Grant is offered only while the PC is below the phase limit, to bound each phase.
    assign i_imem_gnt = gnt_en && (i_pc < pc_limit);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge i_clk);
        #2;
    endtask

    task automatic expect_fetch(input logic [63:0] pc);
        exp_q.push_back({pc, 32'h13 + pc[31:0]});
    endtask

    // PC block model: advance by 4 when consumed, load the redirect target after a flush.
    initial begin
        logic stall_s;
        logic flush_s;
        i_pc = 64'h0;
        forever begin
            @(negedge i_clk);
            stall_s = o_pc_stall;
            flush_s = i_flush;
            @(posedge i_clk);
            #1;
            if (flush_s) i_pc = flush_pc;
            else if (!stall_s) i_pc = i_pc + 64'd4;
        end
    end

    // Instruction memory: answers each granted address one cycle later, in order.
    initial begin
        logic [63:0] a;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = 32'h0;
        forever begin
            @(negedge i_clk);
            if (i_rstn && o_imem_req && i_imem_gnt) pend_q.push_back(o_imem_addr);
            @(posedge i_clk);
            #3;
            if (resp_en && pend_q.size() > 0) begin
                a = pend_q.pop_front();
                i_imem_rvalid = 1'b1;
                i_imem_rdata  = 32'h13 + a[31:0];
            end else begin
                i_imem_rvalid = 1'b0;
                i_imem_rdata  = 32'h0;
            end
        end
    end

    // Scoreboard monitor: every accepted decode transfer must match the next expected entry.
    initial begin
        logic [95:0] e;
        forever begin
            @(negedge i_clk);
            if (i_rstn && o_id_valid && i_id_ready && !i_flush) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got pc %h instr %h expected nothing", o_id_pc, o_id_instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("id_pc", o_id_pc, e[95:32]);
                    chk("id_instr", {32'h0, o_id_instr}, {32'h0, e[31:0]});
                end
            end
        end
    end

    initial begin
        i_rstn     = 1'b0;
        i_flush    = 1'b0;
        i_id_ready = 1'b1;
        gnt_en     = 1'b1;
        resp_en    = 1'b1;
        pc_limit   = 64'd16;
        flush_pc   = 64'h0;

        // Reset held three cycles with grant offered
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            chk("rst_req", {63'h0, o_imem_req}, 64'd0);
            chk("rst_stall", {63'h0, o_pc_stall}, 64'd1);
            chk("rst_id_valid", {63'h0, o_id_valid}, 64'd0);
        end
        chk("rst_id_pc", o_id_pc, 64'h0);
        chk("rst_id_instr", {32'h0, o_id_instr}, 64'h0);
        expect_fetch(64'd0);
        expect_fetch(64'd4);
        expect_fetch(64'd8);
        expect_fetch(64'd12);
        @(posedge i_clk);
        #2;
        i_rstn = 1'b1;
        @(negedge i_clk);
        chk("rel_req", {63'h0, o_imem_req}, 64'd1);
        chk("rel_addr", o_imem_addr, 64'h0);

        // Streaming drains; then back-pressure fills the queue with pcs 16 and 20
        wait_cyc(14);
        i_id_ready = 1'b0;
        pc_limit   = 64'h1000;
        wait_cyc(6);
        @(negedge i_clk);
        chk("bp_req", {63'h0, o_imem_req}, 64'd0);
        chk("bp_stall", {63'h0, o_pc_stall}, 64'd1);
        chk("bp_valid", {63'h0, o_id_valid}, 64'd1);
        chk("bp_head_pc", o_id_pc, 64'd16);
        chk("bp_head_instr", {32'h0, o_id_instr}, 64'h23);
        chk("bp_addr", o_imem_addr, 64'd24);
        wait_cyc(3);
        @(negedge i_clk);
        chk("bp_hold_pc", o_id_pc, 64'd16);
        expect_fetch(64'd16);
        expect_fetch(64'd20);
        expect_fetch(64'd24);
        wait_cyc(1);
        pc_limit   = 64'd28;
        i_id_ready = 1'b1;

        // Flush with two requests outstanding (pcs 28, 32), responses held back
        wait_cyc(10);
        resp_en  = 1'b0;
        pc_limit = 64'h1000;
        wait_cyc(5);
        @(negedge i_clk);
        chk("fl1_stall_full", {63'h0, o_pc_stall}, 64'd1);
        expect_fetch(64'h100);
        wait_cyc(1);
        i_flush  = 1'b1;
        flush_pc = 64'h100;
        pc_limit = 64'h104;
        @(negedge i_clk);
        chk("fl1_req_in_flush", {63'h0, o_imem_req}, 64'd0);
        wait_cyc(1);
        i_flush = 1'b0;
        resp_en = 1'b1;
        @(negedge i_clk);
        chk("fl1_valid_after", {63'h0, o_id_valid}, 64'd0);
        chk("fl1_new_addr", o_imem_addr, 64'h100);

        // Flush coinciding with a response: only the other request is killed
        wait_cyc(10);
        resp_en  = 1'b0;
        pc_limit = 64'h10C;
        wait_cyc(5);
        expect_fetch(64'h200);
        i_flush  = 1'b1;
        flush_pc = 64'h200;
        pc_limit = 64'h204;
        resp_en  = 1'b1;
        wait_cyc(1);
        i_flush = 1'b0;
        @(negedge i_clk);
        chk("fl2_valid_after", {63'h0, o_id_valid}, 64'd0);
        chk("fl2_req_resume", {63'h0, o_imem_req}, 64'd1);
        chk("fl2_addr", o_imem_addr, 64'h200);

        // Grant withheld for five cycles, then a single request at 0x204
        wait_cyc(8);
        gnt_en   = 1'b0;
        pc_limit = 64'h208;
        expect_fetch(64'h204);
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            chk("gw_stall", {63'h0, o_pc_stall}, 64'd1);
            chk("gw_addr", o_imem_addr, 64'h204);
            wait_cyc(1);
        end
        gnt_en = 1'b1;
        @(negedge i_clk);
        chk("gw_granted", {63'h0, o_pc_stall}, 64'd0);
        chk("gw_req", {63'h0, o_imem_req}, 64'd1);

        wait_cyc(8);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
